ddr3_rw_arbiter: RTL and testbench
==================================

# ddr3_rw_arbiter

Burst scheduler between the write FIFO, the read FIFO and the DDR3 controller's user command port. Watches the FIFO water levels and issues one fixed-length write or read burst at a time, with round-robin arbitration when both directions are ready. It drives the FIFO enables (`wfifo_rden`, `rfifo_wren`) and generates wrapping write and read addresses. It sits in the `clk_100` domain between `ddr3_fifo_ctrl` and the DDR3 IP.

## Interface
- `BURST_LEN`, 64: 128-bit beats per burst, power of two, 2..256.
- `ADDR_W`, 28: DDR3 user address width.
- `WR_BASE`, 0: first write address.
- `WR_END`, 28'd1024000: write address wrap limit (exclusive).
- `RD_BASE`, 0: first read address.
- `RD_END`, 28'd1024000: read address wrap limit (exclusive).
- `RFIFO_DEPTH`, 1024: read FIFO depth in 128-bit words.

- `clk_100` in 1: user clock. All logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `init_done` in 1: DDR3 calibration complete.
- `rd_enable` in 1: read path allowed, for example once the first frame has been written.
- `wfifo_rcount` in 11: write FIFO read-side water level.
- `rfifo_wcount` in 11: read FIFO write-side water level.
- `cmd_valid` out 1: command request.
- `cmd_rd` out 1: 1 = read, 0 = write. Valid while `cmd_valid`.
- `cmd_addr` out ADDR_W: burst start address.
- `cmd_len` out 8: `BURST_LEN-1`, constant.
- `cmd_ready` in 1: controller accepts the command.
- `wdata_ready` in 1: controller accepts a write beat.
- `wfifo_rden` out 1: write FIFO read strobe. Also used as the controller write-data valid.
- `rdata_valid` in 1: controller read beat valid.
- `rfifo_wren` out 1: read FIFO write strobe.
- `busy` out 1: a burst is in progress.

## Operation
- States:
  - INIT: wait for `init_done`.
  - IDLE
  - WR_CMD
  - WR_DATA
  - RD_CMD
  - RD_DATA
- INIT→IDLE when `init_done`=1. `init_done` is sampled only in INIT.
- In IDLE, two request conditions are evaluated:
  - `wr_req` = `wfifo_rcount` ≥ `BURST_LEN`.
  - `rd_req` = `rd_enable` && (`rfifo_wcount` + `BURST_LEN` ≤ `RFIFO_DEPTH`). The sum is computed at 12 bits, with no overflow.
- Arbitration:
  - Only one request: grant it.
  - Both requests: grant the direction not granted last. The `last_rd` flag resets to 1, so the first contested grant is a write.
  - `last_rd` updates at the grant.
- WR_CMD / RD_CMD:
  - `cmd_valid`=1. `cmd_rd`, `cmd_addr` and `cmd_len` are held stable until `cmd_ready`.
  - On the `cmd_valid`&&`cmd_ready` cycle, go to WR_DATA / RD_DATA.
- WR_DATA:
  - `wfifo_rden` = `wdata_ready` && (`beat_cnt` < `BURST_LEN`). This is combinational from the state and `wdata_ready`.
  - The write FIFO is used in show-ahead mode, so `wfifo_dout` is valid in the same cycle as `wfifo_rden`.
  - `beat_cnt` increments on each `wfifo_rden`. After beat `BURST_LEN`, go to IDLE.
- RD_DATA:
  - `rfifo_wren` = `rdata_valid`, gated by state.
  - `beat_cnt` counts beats. After beat `BURST_LEN`, go to IDLE.
  - `rdata_valid` outside RD_DATA is ignored; `rfifo_wren` stays 0.
- Address update:
  - On burst completion, the direction's address advances by `BURST_LEN`×8.
  - If the new address would be ≥ its `*_END`, it loads `*_BASE` instead.
  - Write and read addresses are independent registers, reset to `WR_BASE` and `RD_BASE`.
- `busy` = 1 in WR_CMD, WR_DATA, RD_CMD and RD_DATA.

## Timing
- Reset values:
  - State INIT, `beat_cnt`=0, `last_rd`=1.
  - Addresses at their bases.
  - `cmd_valid`, `cmd_rd`, `busy`, `wfifo_rden` and `rfifo_wren` all 0. `cmd_addr`=`WR_BASE`.
- Grant latency: IDLE sees a request in cycle N, `cmd_valid` goes high in N+1 (registered), and `cmd_addr` is registered at the same time.
- Minimum write burst: 1 command cycle + `BURST_LEN` data cycles, then 1 IDLE cycle before the next grant.
- `wdata_ready` low stalls beats; `wfifo_rden` holds 0 and `beat_cnt` holds.
- Water levels are sampled only in IDLE. Changes during a burst do not abort it.
- A mid-burst `rst_n` assertion returns immediately to INIT and clears all outputs. A partial burst is not completed.
- `cmd_len` is constant and has no reset dependency.

## Test plan
- **Init gating:** hold `init_done`=0 with `wfifo_rcount`=200 for 50 cycles → `cmd_valid` stays 0. Raise `init_done` → within 2 cycles `cmd_valid`=1, `cmd_rd`=0, `cmd_addr`=0.
- **Write burst with backpressure:** `BURST_LEN`=64, `wdata_ready` toggling every cycle → exactly 64 `wfifo_rden` pulses. Next write `cmd_addr`=512.
- **Round-robin:** `wfifo_rcount`=300, `rfifo_wcount`=0 and `rd_enable`=1, held constant → grant sequence W, R, W, R. Read addresses 0, 512.
- **Read threshold:** `rfifo_wcount`=960 → read granted. `rfifo_wcount`=961 → no read.
- **Wrap:** `WR_END`=1024, `BURST_LEN`=64 → write addresses 0, 512, 0.
- **Reset mid-burst:** assert `rst_n`=0 after 10 write beats → on the next edge, state INIT, `wfifo_rden`=0, `busy`=0. After release, the first address is `WR_BASE` again.

Source files
------------

// File: rtl/ddr3_rw_arbiter_if.sv
// ddr3_rw_arbiter_if: FIFO water levels, DDR3 user command port and beat strobes seen by the burst arbiter.
interface ddr3_rw_arbiter_if #(
    parameter int ADDR_W = 28
);
    logic              init_done;
    logic              rd_enable;
    logic [10:0]       wfifo_rcount;
    logic [10:0]       rfifo_wcount;
    logic              cmd_valid;
    logic              cmd_rd;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_len;
    logic              cmd_ready;
    logic              wdata_ready;
    logic              wfifo_rden;
    logic              rdata_valid;
    logic              rfifo_wren;
    logic              busy;

    modport master (
        input  init_done, rd_enable, wfifo_rcount, rfifo_wcount, cmd_ready, wdata_ready, rdata_valid,
        output cmd_valid, cmd_rd, cmd_addr, cmd_len, wfifo_rden, rfifo_wren, busy
    );

    modport slave (
        output init_done, rd_enable, wfifo_rcount, rfifo_wcount, cmd_ready, wdata_ready, rdata_valid,
        input  cmd_valid, cmd_rd, cmd_addr, cmd_len, wfifo_rden, rfifo_wren, busy
    );
endinterface

// File: rtl/ddr3_rw_arbiter.sv
// ddr3_rw_arbiter: issues one fixed-length DDR3 write or read burst at a time,
// round-robin between directions, with independent wrapping addresses.
module ddr3_rw_arbiter #(
    parameter int                BURST_LEN   = 64,
    parameter int                ADDR_W      = 28,
    parameter logic [ADDR_W-1:0] WR_BASE     = '0,
    parameter logic [ADDR_W-1:0] WR_END      = 28'd1024000,
    parameter logic [ADDR_W-1:0] RD_BASE     = '0,
    parameter logic [ADDR_W-1:0] RD_END      = 28'd1024000,
    parameter int                RFIFO_DEPTH = 1024
) (
    input logic          clk_100,
    input logic          rst_n,
    ddr3_rw_arbiter_if.master bus
);
    typedef enum logic [2:0] {INIT, IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA} state_t;

    localparam int                CW   = $clog2(BURST_LEN) + 1;
    localparam logic [ADDR_W:0]   STEP = (ADDR_W+1)'(BURST_LEN * 8);

    state_t            state;
    logic [CW-1:0]     beat_cnt;
    logic              last_rd;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   wr_next;
    logic [ADDR_W:0]   rd_next;
    logic [11:0]       rd_sum;
    logic              wr_req;
    logic              rd_req;
    logic              wr_grant;
    logic              last_beat;

    assign bus.cmd_len = 8'(BURST_LEN - 1);

    // Read space check is done one bit wider so a near-full FIFO can't wrap past the depth.
    assign rd_sum    = {1'b0, bus.rfifo_wcount} + 12'(BURST_LEN);
    assign wr_req    = bus.wfifo_rcount >= 11'(BURST_LEN);
    assign rd_req    = bus.rd_enable && (rd_sum <= 12'(RFIFO_DEPTH));
    assign wr_grant  = wr_req && (!rd_req || last_rd);
    assign last_beat = beat_cnt == CW'(BURST_LEN - 1);
    assign wr_next   = {1'b0, wr_addr} + STEP;
    assign rd_next   = {1'b0, rd_addr} + STEP;

    assign bus.wfifo_rden = (state == WR_DATA) && bus.wdata_ready && (beat_cnt < CW'(BURST_LEN));
    assign bus.rfifo_wren = (state == RD_DATA) && bus.rdata_valid;

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state         <= INIT;
            beat_cnt      <= '0;
            last_rd       <= 1'b1;
            wr_addr       <= WR_BASE;
            rd_addr       <= RD_BASE;
            bus.cmd_valid <= 1'b0;
            bus.cmd_rd    <= 1'b0;
            bus.cmd_addr  <= WR_BASE;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                INIT: if (bus.init_done) state <= IDLE;
                IDLE: begin
                    if (wr_grant) begin
                        state         <= WR_CMD;
                        bus.cmd_valid <= 1'b1;
                        bus.cmd_rd    <= 1'b0;
                        bus.cmd_addr  <= wr_addr;
                        bus.busy      <= 1'b1;
                        last_rd       <= 1'b0;
                    end else if (rd_req) begin
                        state         <= RD_CMD;
                        bus.cmd_valid <= 1'b1;
                        bus.cmd_rd    <= 1'b1;
                        bus.cmd_addr  <= rd_addr;
                        bus.busy      <= 1'b1;
                        last_rd       <= 1'b1;
                    end
                end
                WR_CMD, RD_CMD: begin
                    if (bus.cmd_ready) begin
                        state         <= (state == WR_CMD) ? WR_DATA : RD_DATA;
                        bus.cmd_valid <= 1'b0;
                        beat_cnt      <= '0;
                    end
                end
                WR_DATA: begin
                    if (bus.wfifo_rden) begin
                        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                        if (last_beat) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                            wr_addr  <= (wr_next >= {1'b0, WR_END}) ? WR_BASE : wr_next[ADDR_W-1:0];
                        end
                    end
                end
                RD_DATA: begin
                    if (bus.rfifo_wren) begin
                        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                        if (last_beat) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                            rd_addr  <= (rd_next >= {1'b0, RD_END}) ? RD_BASE : rd_next[ADDR_W-1:0];
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// tb_ddr3_rw_arbiter: directed vector table for grants/addresses plus hand sequences for
// init gating, backpressure, wrap and mid-burst reset.
module tb_ddr3_rw_arbiter;
    logic clk_100 = 1'b0;
    logic rst_n   = 1'b0;
    int   n_vec   = 0;
    int   n_fail  = 0;

    ddr3_rw_arbiter_if #(.ADDR_W(28)) bus ();

    ddr3_rw_arbiter #(.BURST_LEN(64), .ADDR_W(28), .WR_END(28'd1024)) dut (
        .clk_100 (clk_100),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_100 = ~clk_100;

    typedef struct {
        logic [10:0] wc;
        logic [10:0] rc;
        logic        re;
        logic        gnt;
        logic        rd;
        logic [27:0] addr;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Entered one half-cycle after a grant; finishes the command handshake and all beats.
    task automatic serve(input logic rd, input logic toggle, input logic [27:0] addr);
        int   cnt;
        int   stray;
        int   cyc;
        logic gate;
        bus.wfifo_rcount = '0;
        bus.rfifo_wcount = '0;
        bus.rd_enable    = 1'b0;
        @(negedge clk_100); #1;
        check("cmd_hold_valid", 32'(bus.cmd_valid), 32'd1);
        check("cmd_hold_addr", 32'(bus.cmd_addr), 32'(addr));
        check("cmd_hold_rd", 32'(bus.cmd_rd), 32'(rd));
        bus.cmd_ready = 1'b1;
        @(negedge clk_100); #1;
        bus.cmd_ready = 1'b0;
        check("cmd_drop", 32'(bus.cmd_valid), 32'd0);
        cnt = 0;
        stray = 0;
        cyc = 0;
        while (cnt < 64 && cyc < 400) begin
            gate = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.wdata_ready = rd ? 1'b1 : gate;
            bus.rdata_valid = rd ? gate : 1'b1;
            #1;
            if (rd ? bus.rfifo_wren : bus.wfifo_rden) cnt++;
            if (rd ? bus.wfifo_rden : bus.rfifo_wren) stray++;
            cyc++;
            if (cnt < 64) begin
                @(negedge clk_100); #1;
            end
        end
        @(negedge clk_100); #1;
        bus.wdata_ready = 1'b0;
        bus.rdata_valid = 1'b0;
        check("beat_count", 32'(cnt), 32'd64);
        check("stray_strobe", 32'(stray), 32'd0);
        check("busy_after", 32'(bus.busy), 32'd0);
        check("rden_after", 32'(bus.wfifo_rden), 32'd0);
    endtask

    initial begin
        int idle_viol;
        tbl[0]  = '{11'd63,   11'd0,    1'b0, 1'b0, 1'b0, 28'd0};
        tbl[1]  = '{11'd64,   11'd0,    1'b0, 1'b1, 1'b0, 28'd512};
        tbl[2]  = '{11'd0,    11'd0,    1'b1, 1'b1, 1'b1, 28'd0};
        tbl[3]  = '{11'd300,  11'd0,    1'b1, 1'b1, 1'b0, 28'd0};
        tbl[4]  = '{11'd300,  11'd0,    1'b1, 1'b1, 1'b1, 28'd512};
        tbl[5]  = '{11'd300,  11'd0,    1'b1, 1'b1, 1'b0, 28'd512};
        tbl[6]  = '{11'd300,  11'd0,    1'b1, 1'b1, 1'b1, 28'd1024};
        tbl[7]  = '{11'd0,    11'd961,  1'b1, 1'b0, 1'b0, 28'd0};
        tbl[8]  = '{11'd0,    11'd960,  1'b1, 1'b1, 1'b1, 28'd1536};
        tbl[9]  = '{11'd100,  11'd2047, 1'b0, 1'b1, 1'b0, 28'd0};
        tbl[10] = '{11'd0,    11'd0,    1'b0, 1'b0, 1'b0, 28'd0};
        tbl[11] = '{11'd2047, 11'd2047, 1'b1, 1'b1, 1'b0, 28'd512};
        tbl[12] = '{11'd64,   11'd960,  1'b1, 1'b1, 1'b1, 28'd2048};
        tbl[13] = '{11'd64,   11'd0,    1'b0, 1'b1, 1'b0, 28'd0};

        bus.init_done    = 1'b0;
        bus.rd_enable    = 1'b0;
        bus.wfifo_rcount = 11'd200;
        bus.rfifo_wcount = '0;
        bus.cmd_ready    = 1'b0;
        bus.wdata_ready  = 1'b0;
        bus.rdata_valid  = 1'b1;
        repeat (3) @(negedge clk_100);
        #1;
        check("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        check("rst_cmd_rd", 32'(bus.cmd_rd), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rden", 32'(bus.wfifo_rden), 32'd0);
        check("rst_wren", 32'(bus.rfifo_wren), 32'd0);
        check("rst_cmd_addr", 32'(bus.cmd_addr), 32'd0);
        check("cmd_len", 32'(bus.cmd_len), 32'd63);

        rst_n = 1'b1;
        bus.rdata_valid = 1'b0;
        idle_viol = 0;
        repeat (50) begin
            @(negedge clk_100); #1;
            if (bus.cmd_valid || bus.busy) idle_viol++;
        end
        check("init_gate", 32'(idle_viol), 32'd0);
        bus.init_done = 1'b1;
        repeat (2) @(negedge clk_100);
        #1;
        check("init_grant_valid", 32'(bus.cmd_valid), 32'd1);
        check("init_grant_rd", 32'(bus.cmd_rd), 32'd0);
        check("init_grant_addr", 32'(bus.cmd_addr), 32'd0);
        serve(1'b0, 1'b1, 28'd0);

        for (int i = 0; i < 14; i++) begin
            bus.wfifo_rcount = tbl[i].wc;
            bus.rfifo_wcount = tbl[i].rc;
            bus.rd_enable    = tbl[i].re;
            @(negedge clk_100); #1;
            check($sformatf("vec%0d_valid", i), 32'(bus.cmd_valid), 32'(tbl[i].gnt));
            check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(tbl[i].gnt));
            if (tbl[i].gnt) begin
                check($sformatf("vec%0d_rd", i), 32'(bus.cmd_rd), 32'(tbl[i].rd));
                check($sformatf("vec%0d_addr", i), 32'(bus.cmd_addr), 32'(tbl[i].addr));
                serve(tbl[i].rd, 1'(i % 2), tbl[i].addr);
            end
        end

        bus.wfifo_rcount = 11'd200;
        @(negedge clk_100); #1;
        check("mid_grant_addr", 32'(bus.cmd_addr), 32'd512);
        bus.wfifo_rcount = '0;
        bus.cmd_ready = 1'b1;
        @(negedge clk_100); #1;
        bus.cmd_ready = 1'b0;
        bus.wdata_ready = 1'b1;
        repeat (10) @(posedge clk_100);
        @(negedge clk_100); #1;
        check("mid_busy", 32'(bus.busy), 32'd1);
        check("mid_rden", 32'(bus.wfifo_rden), 32'd1);
        rst_n = 1'b0;
        bus.init_done = 1'b0;
        #1;
        check("rst_mid_rden", 32'(bus.wfifo_rden), 32'd0);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_valid", 32'(bus.cmd_valid), 32'd0);
        repeat (2) @(negedge clk_100);
        rst_n = 1'b1;
        bus.wdata_ready = 1'b0;
        bus.wfifo_rcount = 11'd200;
        idle_viol = 0;
        repeat (5) begin
            @(negedge clk_100); #1;
            if (bus.cmd_valid) idle_viol++;
        end
        check("post_rst_init", 32'(idle_viol), 32'd0);
        bus.init_done = 1'b1;
        repeat (2) @(negedge clk_100);
        #1;
        check("post_rst_valid", 32'(bus.cmd_valid), 32'd1);
        check("post_rst_addr", 32'(bus.cmd_addr), 32'd0);
        serve(1'b0, 1'b0, 28'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
